// File: rtl/kuz_pkg.sv
// rtl/kuz_pkg.sv - shared Kuznechik constants and sequencer state type
package kuz_pkg;

    // Low byte of the field polynomial x^8+x^7+x^6+x+1; the x^8 term is implicit.
    localparam logic [7:0] GF_POLY = 8'hC3;

    // Coefficient k multiplies byte x(15-k) in the l function.
    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32,  8'd133, 8'd16,
        8'd194, 8'd192, 8'd1,   8'd251,
        8'd1,   8'd192, 8'd194, 8'd16,
        8'd133, 8'd32,  8'd148, 8'd1
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/l_transform_sequencer_if.sv
// rtl/l_transform_sequencer_if.sv - block in/out handshake bundle (in_inv only with L_INV_EN)
interface l_transform_sequencer_if;

    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
`ifdef L_INV_EN
    logic         in_inv;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

`ifdef L_INV_EN
    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif

endinterface

// File: rtl/kuz_gf_mul8.sv
// rtl/kuz_gf_mul8.sv - combinational GF(2^8) multiply modulo 0x1C3
module kuz_gf_mul8
    import kuz_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);

    logic [7:0] acc;

    // Shift-and-add; with a constant b the unused partial products vanish.
    always_comb begin
        p   = '0;
        acc = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ acc;
            end
            acc = acc[7] ? ({acc[6:0], 1'b0} ^ GF_POLY) : {acc[6:0], 1'b0};
        end
    end

endmodule

// File: rtl/l_transform_sequencer.sv
// rtl/l_transform_sequencer.sv - iterative Kuznechik L (16 x R); L_INV_EN adds R^-1 via in_inv
module l_transform_sequencer
    import kuz_pkg::*;
#(
    parameter int ROUNDS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    l_transform_sequencer_if.slave  bus
);

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    state_t       state, state_n;
    logic [127:0] sr, sr_n;
    logic [3:0]   cnt, cnt_n;
    logic         inv;
    logic         load;
    logic [7:0]   xb   [16];
    logic [7:0]   prod [16];
    logic [7:0]   l_val;
    logic [127:0] step;

`ifdef L_INV_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            inv <= 1'b0;
        end else if (load) begin
            inv <= bus.in_inv;
        end
    end
`else
    assign inv = 1'b0;
`endif

    // xb[i] is operand x_i of l; the inverse step rotates the byte view by one.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            xb[i] = inv ? sr[8*((i + 15) % 16) +: 8] : sr[8*i +: 8];
        end
    end

    for (genvar k = 0; k < 16; k++) begin : g_mul
        kuz_gf_mul8 u_mul (
            .a (xb[15-k]),
            .b (L_COEF[k]),
            .p (prod[k])
        );
    end

    always_comb begin
        l_val = '0;
        for (int k = 0; k < 16; k++) begin
            l_val = l_val ^ prod[k];
        end
    end

    assign step = inv ? {sr[119:0], l_val} : {l_val, sr[127:8]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sr    <= sr_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                sr_n = step;
                if (cnt == LAST) begin
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            DONE: begin
                // Taking the result and a new block in one cycle avoids an IDLE bubble.
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            state_n = RUN;
            sr_n    = bus.in_data;
            cnt_n   = '0;
        end
    end

    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.out_data  = sr;

endmodule

// File: tb/tb_l_transform_sequencer.sv
// tb/tb_l_transform_sequencer.sv - scoreboard bench for l_transform_sequencer (ROUNDS 16 and 1; L_INV_EN optional)
module tb_l_transform_sequencer;

    localparam logic [7:0] COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mode = 0;
    logic drv_inv = 1'b0;

    logic         ovr_en = 1'b0;
    logic [127:0] ovr_val = '0;
    logic         ovr1_en = 1'b0;
    logic [127:0] ovr1_val = '0;

    logic [127:0] exp_q[$];
    int           acc_q[$];
    logic [127:0] exp1_q[$];
    int           acc1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    l_transform_sequencer_if bus ();
    l_transform_sequencer_if bus1 ();

    l_transform_sequencer #(.ROUNDS(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    l_transform_sequencer #(.ROUNDS(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ (16'(a) << i);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (16'h01C3 << (k - 8));
        end
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_l(input logic [127:0] d, input logic inv, input int rounds);
        logic [7:0]   b [16];
        logic [7:0]   x [16];
        logic [7:0]   t;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = d[8*i +: 8];
        for (int n = 0; n < rounds; n++) begin
            for (int i = 0; i < 16; i++) x[i] = inv ? b[(i + 15) % 16] : b[i];
            t = '0;
            for (int i = 0; i < 16; i++) t = t ^ gmul(COEF[15-i], x[i]);
            if (!inv) begin
                for (int i = 0; i < 15; i++) b[i] = b[i+1];
                b[15] = t;
            end else begin
                for (int i = 15; i > 0; i--) b[i] = b[i-1];
                b[0] = t;
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    // Input side: an accepted block pushes its expected result and acceptance cycle.
    initial forever begin
        logic inv0, inv1;
        @(negedge clk);
        if (rst) begin
            exp_q.delete();  acc_q.delete();
            exp1_q.delete(); acc1_q.delete();
        end else begin
`ifdef L_INV_EN
            inv0 = bus.in_inv;  inv1 = bus1.in_inv;
`else
            inv0 = 1'b0;        inv1 = 1'b0;
`endif
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ovr_en ? ovr_val : ref_l(bus.in_data, inv0, 16));
                acc_q.push_back(cyc);
                ovr_en = 1'b0;
            end
            if (bus1.in_valid && bus1.in_ready) begin
                exp1_q.push_back(ovr1_en ? ovr1_val : ref_l(bus1.in_data, inv1, 1));
                acc1_q.push_back(cyc);
                ovr1_en = 1'b0;
            end
        end
    end

    // Output side for ROUNDS=16: latency, data and stall stability.
    initial begin
        bit           seen;
        bit           hold;
        logic [127:0] held;
        seen = 0; hold = 0; held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 0; hold = 0;
            end else begin
                if (hold) begin
                    chk("stall_valid", 128'(bus.out_valid), 128'd1);
                    chk("stall_data", bus.out_data, held);
                    hold = 0;
                end
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_out actual=%h required=no pending block", bus.out_data);
                    end else begin
                        if (!seen) begin
                            chk("latency16", 128'(cyc), 128'(acc_q[0] + 17));
                            seen = 1;
                        end
                        if (bus.out_ready) begin
                            chk("data16", bus.out_data, exp_q.pop_front());
                            void'(acc_q.pop_front());
                            seen = 0;
                        end else begin
                            hold = 1;
                            held = bus.out_data;
                        end
                    end
                end
            end
        end
    end

    // Output side for ROUNDS=1 (consumer always ready).
    initial begin
        bit seen1;
        seen1 = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen1 = 0;
            end else if (bus1.out_valid) begin
                if (exp1_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_out1 actual=%h required=no pending block", bus1.out_data);
                end else begin
                    if (!seen1) begin
                        chk("latency1", 128'(cyc), 128'(acc1_q[0] + 2));
                        seen1 = 1;
                    end
                    if (bus1.out_ready) begin
                        chk("data1", bus1.out_data, exp1_q.pop_front());
                        void'(acc1_q.pop_front());
                        seen1 = 0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input int which, input logic [127:0] d, output int acc);
        acc = -1;
        if (which == 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = d;
`ifdef L_INV_EN
            bus.in_inv   = drv_inv;
`endif
        end else begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = d;
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if ((which == 0) ? bus.in_ready : bus1.in_ready) begin
                acc = cyc;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (acc < 0) begin
            checks++; failures++;
            $display("FAIL send_timeout actual=no accept required=accept within 200 cycles");
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus1.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        idle(0);
        for (t = 0; t < 400; t++) begin
            if (exp_q.size() == 0 && exp1_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        if (t == 400) begin
            checks++; failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0 pending", exp_q.size() + exp1_q.size());
        end
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_data", bus.out_data, 128'd0);
        chk("rst_out_valid1", 128'(bus1.out_valid), 128'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1;
        logic [127:0] v;
        bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b1;
`ifdef L_INV_EN
        bus.in_inv = 1'b0; bus1.in_inv = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();

        // Single step, known vector, then random single steps.
        v = 128'h00000000000000000000000000000100;
        ovr1_val = 128'h94000000000000000000000000000001;
        ovr1_en  = 1'b1;
        send(1, v, a0);
        for (int i = 0; i < 6; i++) begin
            send(1, rand128(), a0);
            idle($urandom_range(0, 2));
        end
        drain();

        // Full L known vector.
        ovr_val = 128'hd456584dd0e3e84cc3166e4b7fa2890d;
        ovr_en  = 1'b1;
        send(0, 128'h64a59400000000000000000000000000, a0);
        drain();

        // Back-to-back: next block accepted in the cycle the result is taken.
        mode = 0;
        ovr_val = 128'h79d26221b87b584cd42fbc4ffea5de9a;
        ovr_en  = 1'b1;
        send(0, 128'hd456584dd0e3e84cc3166e4b7fa2890d, a0);
        for (int i = 0; i < 4; i++) begin
            send(0, rand128(), a1);
            chk("b2b_gap", 128'(a1 - a0), 128'd17);
            a0 = a1;
        end
        drain();

        // Backpressure: hold DONE for 10 cycles.
        mode = 2;
        send(0, rand128(), a0);
        idle(0);
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.out_valid) break;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        mode = 0;
        drain();

        // Reset at RUN step 7, then a clean block.
        send(0, rand128(), a0);
        idle(7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state();
        send(0, rand128(), a0);
        drain();

        // Random traffic with random consumer stalls.
        mode = 1;
        for (int i = 0; i < 30; i++) begin
`ifdef L_INV_EN
            drv_inv = 1'($urandom_range(0, 1));
`endif
            send(0, rand128(), a0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end
        drain();
        mode = 0;

`ifdef L_INV_EN
        drv_inv = 1'b1;
        ovr_val = 128'h64a59400000000000000000000000000;
        ovr_en  = 1'b1;
        send(0, 128'hd456584dd0e3e84cc3166e4b7fa2890d, a0);
        drv_inv = 1'b0;
        drain();
`endif

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l_transform_sequencer.md
# l_transform_sequencer

Iterative sequencer for the Kuznechik linear transform L, built as 16 applications of the byte-shift step R. It accepts one 128-bit block on a valid/ready input and runs the R steps, one per clock, over an internal shift register. Each step computes the GF(2^8) linear function l with constant multipliers. The result is returned on a valid/ready output. It sits between the S-box stage and the round-key XOR in the cipher round datapath.

## Interface
Parameters:
- ROUNDS, default 16: number of R steps per block, legal range 1..16. ROUNDS=1 is used only for single-step verification.

Ports:
- clk, in, 1: single clock; all state updates on its rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input block is valid.
- in_ready, out, 1: block can accept input.
- in_data, in, 128: block a15..a0, with a15 = in_data[127:120].
- in_inv, in, 1: selects the inverse transform; sampled with in_data. Present only with L_INV_EN.
- out_valid, out, 1: result is valid.
- out_ready, in, 1: consumer accepts the result.
- out_data, out, 128: transformed block, same byte order as in_data.

## Operation
States: IDLE, RUN, DONE.

IDLE:
- in_ready=1.
- On in_valid&&in_ready: load shift reg <= in_data, cnt <= 0, latch inv, go to RUN.

RUN:
- Each cycle applies one step: R, or R^-1 when inv is set.
- cnt increments.
- When cnt==ROUNDS-1, the step completes and the state goes to DONE.

DONE:
- out_valid=1 and out_data = shift reg, both held stable until out_ready.
- On out_ready:
  - if in_valid is also high, the new block loads directly into RUN;
  - otherwise go to IDLE.

Handshake:
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready; no other combinational paths exist.

l(x15..x0):
- l = 148·x15 ^ 32·x14 ^ 133·x13 ^ 16·x12 ^ 194·x11 ^ 192·x10 ^ 1·x9 ^ 251·x8 ^ 1·x7 ^ 192·x6 ^ 194·x5 ^ 16·x4 ^ 133·x3 ^ 32·x2 ^ 148·x1 ^ 1·x0.
- Multiplication is in GF(2^8) modulo x^8+x^7+x^6+x+1 (0x1C3).
- Addition is XOR, so there is no carry or width growth. Every product and the sum are 8 bits.

Forward step R:
- sr <= {l(sr[127:120],…,sr[7:0]), sr[127:8]}.

Inverse step R^-1:
- sr <= {sr[119:0], l(sr[119:112],…,sr[7:0], sr[127:120])}.

Counter:
- cnt is 4 bits and never wraps mid-block. It is reset to 0 on every load.

Reset:
- rst has priority over everything. It forces IDLE, cnt=0, and out_valid=0, and an in-flight block is discarded.
- in_ready=1 in the cycle after reset release.
- After reset: out_data=0, sr=0, inv=0.

## Timing
Latency:
- Capture edge E0, R steps at edges E1..E_ROUNDS.
- out_valid rises after edge E_ROUNDS. For ROUNDS=16 that is 16 cycles after acceptance.

Throughput:
- With out_ready held high and in_valid held high, one block is accepted every ROUNDS+1 cycles. There are no bubble cycles beyond the DONE cycle.

Backpressure:
- DONE holds indefinitely. out_data must not change while out_valid=1 && out_ready=0.

Reset mid-operation:
- rst in RUN or DONE gives out_valid=0 on the next edge. No partial result is ever presented.

## Configuration
L_INV_EN:
- Defined: the in_inv port exists and the R^-1 datapath is built. inv is latched per block, so changing in_inv while in RUN has no effect.
- Undefined: the in_inv port is absent, only forward L is built, and inv is tied to 0.

## Structure
Shared package kuz_pkg holds:
- the GF polynomial constant 8'hC3;
- the 16-entry l coefficient array (148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1);
- the state enum typedef (IDLE/RUN/DONE).

Sub-module kuz_gf_mul8:
- combinational 8×8 GF(2^8) multiply, instantiated 16 times with constant operands so synthesis folds them.
- Both l orderings share the same 16 instances through an input byte mux.

## Test plan
- ROUNDS=1, forward, in_data=00000000000000000000000000000100 → out_data=94000000000000000000000000000001, out_valid after 1 step.
- ROUNDS=16, forward, in_data=64a59400000000000000000000000000 → out_data=d456584dd0e3e84cc3166e4b7fa2890d, exactly 16 cycles after acceptance.
- ROUNDS=16, back-to-back: d456584dd0e3e84cc3166e4b7fa2890d then another block, out_ready=1 → first out_data=79d26221b87b584cd42fbc4ffea5de9a; second block accepted in the same cycle the first result is taken.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_data and out_valid are stable, in_ready=0, and the block is released when out_ready=1.
- rst asserted at RUN step 7 → next cycle out_valid=0, state IDLE, in_ready=1. The next block then yields the correct result.
- With L_INV_EN, in_inv=1, in_data=d456584dd0e3e84cc3166e4b7fa2890d → out_data=64a59400000000000000000000000000.
